// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction field issuer and its decoder:
// major opcodes, instruction field positions, decoded kinds and FSM states.
package isa_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int OPERAND_W = 12;
  localparam int ALU_SUB_W = 8;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_ALU   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Decoded instruction class, independent of the raw opcode encoding
  typedef enum logic [2:0] {
    K_NOP,
    K_LOAD,
    K_STORE,
    K_JUMP,
    K_ALU,
    K_HALT,
    K_ILLEGAL
  } kind_t;

  // Issuer sequencing states
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_ISSUE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/instr_field_issuer_if.sv
// Bus between the issuer and its environment: instruction-memory fetch
// handshake, downstream back-pressure and the shared field bus.
interface instr_field_issuer_if #(
  parameter int PC_W = 12
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic            imem_valid;
  logic            exec_busy;
  logic            select_demux;
  logic [11:0]     data_addr;
  logic [7:0]      opcode2;
  logic            issue_valid;
  logic            halted;
  logic            illegal;

  modport master (
    output imem_req, imem_addr, select_demux, data_addr, opcode2,
           issue_valid, halted, illegal,
    input  imem_data, imem_valid, exec_busy
  );

  modport slave (
    input  imem_req, imem_addr, select_demux, data_addr, opcode2,
           issue_valid, halted, illegal,
    output imem_data, imem_valid, exec_busy
  );

endinterface

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: splits an instruction word into
// its class, 12-bit operand and 8-bit ALU sub-opcode.
module instr_decode
  import isa_pkg::*;
(
  input  logic [INSTR_W-1:0]   ir_i,
  output kind_t                kind_o,
  output logic [OPERAND_W-1:0] operand_o,
  output logic [ALU_SUB_W-1:0] sub_op_o,
  output logic                 is_illegal_o
);

  // Classify the major opcode; anything not listed is illegal
  always_comb begin
    kind_o       = K_ILLEGAL;
    is_illegal_o = 1'b1;
    operand_o    = ir_i[OPERAND_W-1:0];
    sub_op_o     = ir_i[ALU_SUB_W-1:0];
    case (ir_i[OPC_MSB:OPC_LSB])
      OP_NOP:   begin kind_o = K_NOP;   is_illegal_o = 1'b0; end
      OP_LOAD:  begin kind_o = K_LOAD;  is_illegal_o = 1'b0; end
      OP_STORE: begin kind_o = K_STORE; is_illegal_o = 1'b0; end
      OP_JUMP:  begin kind_o = K_JUMP;  is_illegal_o = 1'b0; end
      OP_ALU:   begin kind_o = K_ALU;   is_illegal_o = 1'b0; end
      OP_HALT:  begin kind_o = K_HALT;  is_illegal_o = 1'b0; end
      default:  begin kind_o = K_ILLEGAL; is_illegal_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/instr_field_issuer.sv
// Datapath front-end: fetches instruction words, decodes them and drives the
// shared field bus (data address or ALU sub-opcode) towards the demux.
// Owns the program counter, jump handling and the sticky halt.
module instr_field_issuer
  import isa_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_field_issuer_if.master bus
);

  state_t                state_q;
  logic [PC_W-1:0]       pc_q;
  logic [INSTR_W-1:0]    ir_q;
  logic                  imem_req_q;
  logic                  select_demux_q;
  logic [OPERAND_W-1:0]  data_addr_q;
  logic [ALU_SUB_W-1:0]  opcode2_q;
  logic                  issue_valid_q;
  logic                  halted_q;
  logic                  illegal_q;

  kind_t                 kind;
  logic [OPERAND_W-1:0]  operand;
  logic [ALU_SUB_W-1:0]  sub_op;
  logic                  is_illegal;

  logic [PC_W-1:0]       pc_inc_d;
  logic [PC_W-1:0]       jump_pc_d;

  instr_decode u_decode (
    .ir_i         (ir_q),
    .kind_o       (kind),
    .operand_o    (operand),
    .sub_op_o     (sub_op),
    .is_illegal_o (is_illegal)
  );

  // Sequential PC increment wraps naturally; jump target is resized to PC_W
  assign pc_inc_d  = pc_q + PC_W'(1);
  assign jump_pc_d = PC_W'(operand);

  // Fetch/decode/issue sequencer with all bus outputs held in registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      ir_q           <= '0;
      imem_req_q     <= 1'b0;
      select_demux_q <= 1'b0;
      data_addr_q    <= '0;
      opcode2_q      <= '0;
      issue_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          imem_req_q <= 1'b1;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_valid) begin
            ir_q       <= bus.imem_data;
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_illegal) begin
            illegal_q  <= 1'b1;
            pc_q       <= pc_inc_d;
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end else begin
            case (kind)
              K_LOAD, K_STORE: begin
                select_demux_q <= 1'b1;
                data_addr_q    <= operand;
                issue_valid_q  <= 1'b1;
                state_q        <= ST_ISSUE;
              end
              K_ALU: begin
                select_demux_q <= 1'b0;
                opcode2_q      <= sub_op;
                issue_valid_q  <= 1'b1;
                state_q        <= ST_ISSUE;
              end
              K_JUMP: begin
                pc_q       <= jump_pc_d;
                imem_req_q <= 1'b1;
                state_q    <= ST_FETCH;
              end
              K_HALT: begin
                halted_q <= 1'b1;
                state_q  <= ST_HALT;
              end
              default: begin
                pc_q       <= pc_inc_d;
                imem_req_q <= 1'b1;
                state_q    <= ST_FETCH;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (!bus.exec_busy) begin
            pc_q          <= pc_inc_d;
            issue_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = pc_q;
  assign bus.select_demux = select_demux_q;
  assign bus.data_addr    = data_addr_q;
  assign bus.opcode2      = opcode2_q;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.halted       = halted_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_instr_field_issuer.sv
// Directed bench for instr_field_issuer: plays the instruction memory and the
// downstream consumer, comparing the bus against hand-computed values.
module tb_instr_field_issuer;

  logic clk;
  logic rst;
  int   errorCount;
  int   checkCount;

  instr_field_issuer_if #(.PC_W(12)) bus ();

  instr_field_issuer #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and reports and counts a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // All outputs at their reset values
  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"},   {31'd0, bus.imem_req},     32'd0);
    checkOutput({tag, "_addr"},  {20'd0, bus.imem_addr},    32'h000);
    checkOutput({tag, "_sel"},   {31'd0, bus.select_demux}, 32'd0);
    checkOutput({tag, "_daddr"}, {20'd0, bus.data_addr},    32'd0);
    checkOutput({tag, "_op2"},   {24'd0, bus.opcode2},      32'd0);
    checkOutput({tag, "_iv"},    {31'd0, bus.issue_valid},  32'd0);
    checkOutput({tag, "_halt"},  {31'd0, bus.halted},       32'd0);
    checkOutput({tag, "_ill"},   {31'd0, bus.illegal},      32'd0);
  endtask

  // Memory model: wait for a request, check its address, answer one cycle later
  task automatic applyStimulus(input logic [15:0] word, input logic [11:0] expAddr,
                               input string tag);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req"},  {31'd0, bus.imem_req},  32'd1);
    checkOutput({tag, "_addr"}, {20'd0, bus.imem_addr}, {20'd0, expAddr});
    tick();
    bus.imem_data  = word;
    bus.imem_valid = 1'b1;
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_data  = 16'h0000;
  endtask

  // Wait (bounded) for issue_valid to rise
  task automatic waitIssue(input string tag);
    int n;
    n = 0;
    while (bus.issue_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_iv"}, {31'd0, bus.issue_valid}, 32'd1);
  endtask

  // Directed test sequence
  initial begin
    errorCount     = 0;
    checkCount     = 0;
    rst            = 1'b1;
    bus.imem_data  = 16'h0000;
    bus.imem_valid = 1'b0;
    bus.exec_busy  = 1'b0;
    tick();
    tick();
    checkReset("rst0");
    rst = 1'b0;

    // LOAD 0xABC with one-cycle memory
    applyStimulus(16'h1ABC, 12'h000, "load");
    waitIssue("load");
    checkOutput("load_sel",   {31'd0, bus.select_demux}, 32'd1);
    checkOutput("load_daddr", {20'd0, bus.data_addr},    32'hABC);
    checkOutput("load_op2",   {24'd0, bus.opcode2},      32'h00);
    tick();
    checkOutput("load_done_iv",   {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("load_done_pc",   {20'd0, bus.imem_addr},   32'h001);
    checkOutput("load_done_req",  {31'd0, bus.imem_req},    32'd1);

    // ALU 0x5A held by back-pressure for 5 cycles
    applyStimulus(16'h8F5A, 12'h001, "alu");
    bus.exec_busy = 1'b1;
    waitIssue("alu");
    checkOutput("alu_sel",   {31'd0, bus.select_demux}, 32'd0);
    checkOutput("alu_op2",   {24'd0, bus.opcode2},      32'h5A);
    checkOutput("alu_daddr", {20'd0, bus.data_addr},    32'hABC);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("busy_iv",    {31'd0, bus.issue_valid},  32'd1);
      checkOutput("busy_sel",   {31'd0, bus.select_demux}, 32'd0);
      checkOutput("busy_op2",   {24'd0, bus.opcode2},      32'h5A);
      checkOutput("busy_daddr", {20'd0, bus.data_addr},    32'hABC);
      checkOutput("busy_pc",    {20'd0, bus.imem_addr},    32'h001);
      checkOutput("busy_req",   {31'd0, bus.imem_req},     32'd0);
    end
    bus.exec_busy = 1'b0;
    tick();
    checkOutput("alu_done_iv", {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("alu_done_pc", {20'd0, bus.imem_addr},   32'h002);

    // JUMP to 0xFFE, then NOPs walking through the wrap
    applyStimulus(16'h3FFE, 12'h002, "jump");
    tick();
    checkOutput("jump_iv",  {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("jump_pc",  {20'd0, bus.imem_addr},   32'hFFE);
    applyStimulus(16'h0000, 12'hFFE, "nop0");
    tick();
    checkOutput("nop0_iv",  {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("nop0_pc",  {20'd0, bus.imem_addr},   32'hFFF);
    applyStimulus(16'h0000, 12'hFFF, "nop1");
    tick();
    checkOutput("wrap_iv",  {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("wrap_pc",  {20'd0, bus.imem_addr},   32'h000);

    // Illegal opcode 5: one-cycle pulse, no issue, pc+1
    applyStimulus(16'h5000, 12'h000, "ill");
    checkOutput("ill_pre",  {31'd0, bus.illegal},     32'd0);
    tick();
    checkOutput("ill_pulse", {31'd0, bus.illegal},     32'd1);
    checkOutput("ill_iv",    {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("ill_pc",    {20'd0, bus.imem_addr},   32'h001);
    tick();
    checkOutput("ill_end",   {31'd0, bus.illegal},     32'd0);

    // HALT: sticky, no further requests
    applyStimulus(16'hF000, 12'h001, "halt");
    tick();
    checkOutput("halt_flag", {31'd0, bus.halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("halt_req",  {31'd0, bus.imem_req},    32'd0);
      checkOutput("halt_hold", {31'd0, bus.halted},      32'd1);
      checkOutput("halt_iv",   {31'd0, bus.issue_valid}, 32'd0);
    end

    // Reset while halted, then reset in WAIT with a colliding imem_valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkReset("rst_halt");
    tick();
    checkOutput("wait_req", {31'd0, bus.imem_req}, 32'd1);
    rst            = 1'b1;
    bus.imem_valid = 1'b1;
    bus.imem_data  = 16'h1123;
    tick();
    rst = 1'b0;
    checkReset("rst_wait");
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_data  = 16'h0000;
    checkOutput("late_req",  {31'd0, bus.imem_req},  32'd1);
    checkOutput("late_addr", {20'd0, bus.imem_addr}, 32'h000);
    tick();
    tick();
    checkOutput("late_ignored_req", {31'd0, bus.imem_req},    32'd1);
    checkOutput("late_ignored_iv",  {31'd0, bus.issue_valid}, 32'd0);

    // Reset during a back-pressured STORE issue
    applyStimulus(16'h2123, 12'h000, "store");
    bus.exec_busy = 1'b1;
    waitIssue("store");
    checkOutput("store_sel",   {31'd0, bus.select_demux}, 32'd1);
    checkOutput("store_daddr", {20'd0, bus.data_addr},    32'h123);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkReset("rst_issue");
    bus.exec_busy = 1'b0;

    // Restart from RESET_PC; data_addr retains its reset value
    applyStimulus(16'h8077, 12'h000, "restart");
    waitIssue("restart");
    checkOutput("restart_sel",   {31'd0, bus.select_demux}, 32'd0);
    checkOutput("restart_op2",   {24'd0, bus.opcode2},      32'h77);
    checkOutput("restart_daddr", {20'd0, bus.data_addr},    32'h000);
    tick();
    checkOutput("restart_pc",    {20'd0, bus.imem_addr},    32'h001);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
